// File: rtl/cpu_mc.sv
// Multicycle core with DATA_W-bit datapath, 8-entry register file and NZCV flags.
// It fetches 16-bit instructions over a req/ack port that may insert wait states.
module cpu_mc #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              RESET,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              halted,
    output logic [CNT_W-1:0]  retired,
    output logic [3:0]        cc,
    input  logic [2:0]        dbg_rsel,
    output logic [DATA_W-1:0] dbg_rdata
);

    localparam int unsigned MSB = DATA_W - 1;

    typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_HALT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       ir;
    logic [DATA_W-1:0] regs [8];

    logic [1:0]        cls;
    logic [3:0]        aluop;
    logic              setcc;
    logic [2:0]        rd, ra, rb;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] op_a, op_b, diff, alu_res;
    logic [DATA_W:0]   sum_w;
    logic [4:0]        shamt;
    logic              shift_oob;
    logic              flag_c, flag_v;
    logic [3:0]        flags;
    logic              br_take;
    logic              alu_ok, stop;
    logic [ADDR_W-1:0] pc_inc, br_off, pc_next;

    assign cls     = ir[15:14];
    assign aluop   = ir[13:10];
    assign setcc   = ir[9];
    assign rd      = ir[8:6];
    assign ra      = ir[5:3];
    assign rb      = ir[2:0];
    assign imm_ext = DATA_W'($signed(ir[5:0]));

    assign imem_addr = pc;
    // r0 is never written, so a plain array read returns 0 for it
    assign dbg_rdata = regs[dbg_rsel];

    // ALU and flag generation
    always_comb begin
        op_a      = (cls == 2'b00) ? regs[ra] : regs[rd];
        op_b      = (cls == 2'b00) ? regs[rb] : imm_ext;
        sum_w     = {1'b0, op_a} + {1'b0, op_b};
        diff      = op_a - op_b;
        shamt     = op_b[4:0];
        shift_oob = 32'(shamt) >= DATA_W;
        alu_res   = '0;
        flag_c    = 1'b0;
        flag_v    = 1'b0;
        case (aluop)
            4'd0: begin
                alu_res = sum_w[MSB:0];
                flag_c  = sum_w[DATA_W];
                flag_v  = (op_a[MSB] == op_b[MSB]) && (sum_w[MSB] != op_a[MSB]);
            end
            4'd1: begin
                alu_res = diff;
                flag_c  = op_a >= op_b;
                flag_v  = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
            end
            4'd2:    alu_res = op_a & op_b;
            4'd3:    alu_res = op_a | op_b;
            4'd4:    alu_res = op_a ^ op_b;
            4'd5:    alu_res = shift_oob ? '0 : (op_a << shamt);
            4'd6:    alu_res = shift_oob ? '0 : (op_a >> shamt);
            4'd7:    alu_res = op_b;
            default: alu_res = '0;
        endcase
        flags = {alu_res[MSB], alu_res == '0, flag_c, flag_v};
    end

    // Branch condition and next pc
    always_comb begin
        case (aluop)
            4'd0:    br_take = 1'b1;
            4'd1:    br_take = cc[2];
            4'd2:    br_take = !cc[2];
            4'd3:    br_take = cc[3] ^ cc[0];
            4'd4:    br_take = !(cc[3] ^ cc[0]);
            4'd5:    br_take = cc[1];
            4'd6:    br_take = !cc[1];
            default: br_take = 1'b0;
        endcase
        alu_ok  = !cls[1] && !aluop[3];
        stop    = (cls == 2'b11) || (!cls[1] && aluop[3]);
        pc_inc  = pc + ADDR_W'(2);
        br_off  = ADDR_W'($signed({ir[9:0], 1'b0}));
        pc_next = (cls == 2'b10 && br_take) ? (pc_inc + br_off) : pc_inc;
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state    <= ST_FETCH;
            pc       <= '0;
            ir       <= '0;
            cc       <= '0;
            retired  <= '0;
            imem_req <= 1'b1;
            halted   <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    retired <= retired + CNT_W'(1);
                    pc      <= pc_next;
                    if (alu_ok) begin
                        if (rd != 3'd0) regs[rd] <= alu_res;
                        if (setcc) cc <= flags;
                    end
                    if (stop) begin
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else begin
                        imem_req <= 1'b1;
                        state    <= ST_FETCH;
                    end
                end
                ST_HALT: ;
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mc.sv
// Bench for cpu_mc: an instruction-level reference model checked every cycle,
// directed programs with literal expectations, then random programs and acks.
module tb_cpu_mc;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata;
    logic        halted;
    logic [31:0] retired;
    logic [3:0]  cc;
    logic [2:0]  dbg_rsel = 3'd0;
    logic [15:0] dbg_rdata;

    logic [15:0] mem [0:32767];

    assign imem_rdata = mem[15'(imem_addr >> 1)];

    always #5 clk = ~clk;

    cpu_mc #(.DATA_W(16), .ADDR_W(16), .CNT_W(32)) dut (
        .clk(clk), .RESET(RESET),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .halted(halted), .retired(retired), .cc(cc),
        .dbg_rsel(dbg_rsel), .dbg_rdata(dbg_rdata)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level reference model
    localparam int PH_FETCH = 0;
    localparam int PH_EXEC  = 1;
    localparam int PH_STOP  = 2;

    longint      m_regs [8];
    longint      m_pc;
    logic [3:0]  m_cc;
    longint      m_ret;
    int          phase;
    logic [15:0] m_ir;

    function automatic longint sgn16(input longint x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 0;
        m_pc  = 0;
        m_cc  = 4'b0000;
        m_ret = 0;
        phase = PH_FETCH;
        m_ir  = 16'h0000;
    endtask

    task automatic model_exec(input logic [15:0] ins);
        longint a, b, res, s, sh, off;
        logic   c, v, take, n_f, z_f, c_f, v_f;
        int     op, cls;
        cls = int'(ins[15:14]);
        op  = int'(ins[13:10]);
        m_ret = (m_ret + 1) % 64'h1_0000_0000;
        phase = PH_FETCH;
        if (cls == 3) begin
            phase = PH_STOP;
            m_pc  = (m_pc + 2) % 65536;
        end else if (cls == 2) begin
            n_f = m_cc[3]; z_f = m_cc[2]; c_f = m_cc[1]; v_f = m_cc[0];
            case (op)
                0: take = 1'b1;
                1: take = z_f;
                2: take = !z_f;
                3: take = n_f != v_f;
                4: take = n_f == v_f;
                5: take = c_f;
                6: take = !c_f;
                default: take = 1'b0;
            endcase
            off = longint'(ins[9:0]);
            if (off >= 512) off = off - 1024;
            if (take) m_pc = (m_pc + 2 + 2 * off + 65536) % 65536;
            else      m_pc = (m_pc + 2) % 65536;
        end else if (op >= 8) begin
            phase = PH_STOP;
            m_pc  = (m_pc + 2) % 65536;
        end else begin
            a = (cls == 0) ? m_regs[ins[5:3]] : m_regs[ins[8:6]];
            if (cls == 0) b = m_regs[ins[2:0]];
            else          b = (sgn16(longint'(ins[5:0]) + (ins[5] ? 65536 - 64 : 0)) + 65536) % 65536;
            c  = 1'b0;
            v  = 1'b0;
            sh = b % 32;
            case (op)
                0: begin
                    s = a + b; res = s % 65536; c = s > 65535;
                    s = sgn16(a) + sgn16(b); v = (s > 32767) || (s < -32768);
                end
                1: begin
                    res = (a - b + 65536) % 65536; c = a >= b;
                    s = sgn16(a) - sgn16(b); v = (s > 32767) || (s < -32768);
                end
                2: res = a & b;
                3: res = a | b;
                4: res = a ^ b;
                5: res = (sh >= 16) ? 0 : (a << sh) % 65536;
                6: res = (sh >= 16) ? 0 : a >> sh;
                default: res = b;
            endcase
            if (ins[8:6] != 3'd0) m_regs[ins[8:6]] = res;
            if (ins[9]) m_cc = {res >= 32768, res == 0, c, v};
            m_pc = (m_pc + 2) % 65536;
        end
    endtask

    // Per-cycle compare, then advance the model using the inputs the next edge will see
    always @(negedge clk) begin
        if (RESET) model_reset();
        check("imem_req", longint'(imem_req), (phase == PH_FETCH) ? 1 : 0);
        if (phase == PH_FETCH) check("imem_addr", longint'(imem_addr), m_pc);
        check("halted", longint'(halted), (phase == PH_STOP) ? 1 : 0);
        check("retired", longint'(retired), m_ret);
        check("cc", longint'(cc), longint'(m_cc));
        check("dbg_rdata", longint'(dbg_rdata), m_regs[dbg_rsel]);
        if (!RESET) begin
            if (phase == PH_FETCH) begin
                if (imem_ack) begin
                    m_ir  = imem_rdata;
                    phase = PH_EXEC;
                end
            end else if (phase == PH_EXEC) begin
                model_exec(m_ir);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        RESET    = 1'b1;
        imem_ack = 1'b0;
        repeat (3) tick();
        RESET = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32768; i++) mem[i] = 16'hC000;
    endtask

    function automatic logic [15:0] rand_instr();
        int unsigned r;
        logic [15:0] w;
        r = $urandom_range(0, 99);
        w = 16'($urandom);
        if (r < 40)      w[15:13] = 3'b000;
        else if (r < 75) w[15:13] = 3'b010;
        else if (r < 98) w[15:14] = 2'b10;
        else if (r < 99) w[15:14] = 2'b11;
        else begin
            w[15] = 1'b0;
            w[13] = 1'b1;
        end
        return w;
    endfunction

    initial begin
        // Program A: immediates, flags, wait states, overflow, r0 write, illegal op
        clear_mem();
        mem[0] = 16'h5C7F;  // MOV r1,#-1
        mem[1] = 16'h4241;  // ADD r1,#1 setcc
        mem[2] = 16'h5CBF;  // MOV r2,#-1
        mem[3] = 16'h5881;  // SHR r2,#1
        mem[4] = 16'h5CFF;  // MOV r3,#-1
        mem[5] = 16'h0713;  // SUB r4,r2,r3 setcc
        mem[6] = 16'h1E04;  // MOV r0,r4 setcc
        mem[7] = 16'h3000;  // illegal aluop 0xC
        do_reset();
        imem_ack = 1'b1;
        #1;
        check("rst_req", longint'(imem_req), 1);
        check("rst_addr", longint'(imem_addr), 0);
        check("rst_halted", longint'(halted), 0);
        check("rst_retired", longint'(retired), 0);
        check("rst_cc", longint'(cc), 0);
        repeat (4) tick();
        dbg_rsel = 3'd1;
        imem_ack = 1'b0;
        #1;
        check("imm_r1", longint'(dbg_rdata), 0);
        check("imm_cc", longint'(cc), 4'b0110);
        check("imm_retired", longint'(retired), 2);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 4) imem_ack = 1'b1;
            check("wait_addr", longint'(imem_addr), 16'h0004);
            check("wait_req", longint'(imem_req), 1);
            check("wait_retired", longint'(retired), 2);
        end
        tick();
        check("ack_exec_retired", longint'(retired), 2);
        tick();
        check("ack_done_retired", longint'(retired), 3);
        check("ack_done_addr", longint'(imem_addr), 16'h0006);
        repeat (6) tick();
        dbg_rsel = 3'd4;
        #1;
        check("sub_r4", longint'(dbg_rdata), 16'h8000);
        check("sub_cc", longint'(cc), 4'b1001);
        dbg_rsel = 3'd2;
        #1;
        check("sub_r2", longint'(dbg_rdata), 16'h7FFF);
        repeat (4) tick();
        dbg_rsel = 3'd0;
        #1;
        check("halt_halted", longint'(halted), 1);
        check("halt_req", longint'(imem_req), 0);
        check("halt_retired", longint'(retired), 8);
        check("r0_reads_zero", longint'(dbg_rdata), 0);
        check("r0_write_cc", longint'(cc), 4'b1000);
        repeat (6) tick();
        check("halt_ack_ignored", longint'(retired), 8);

        // Program B: BEQ taken, with a mid-EXEC reset first
        RESET = 1'b1;
        clear_mem();
        mem[0] = 16'h0749;  // SUB r5,r1,r1 setcc
        for (int i = 1; i < 8; i++) mem[i] = 16'h4181;  // ADD r6,#1
        mem[8] = 16'h87F8;  // BEQ -8
        do_reset();
        imem_ack = 1'b1;
        repeat (3) tick();
        check("pre_abort_cc", longint'(cc), 4'b0110);
        check("pre_abort_retired", longint'(retired), 1);
        RESET = 1'b1;
        #1;
        check("abort_req", longint'(imem_req), 1);
        check("abort_addr", longint'(imem_addr), 0);
        check("abort_retired", longint'(retired), 0);
        check("abort_cc", longint'(cc), 0);
        check("abort_halted", longint'(halted), 0);
        tick();
        RESET = 1'b0;
        repeat (18) tick();
        dbg_rsel = 3'd6;
        #1;
        check("beq_addr", longint'(imem_addr), 16'h0002);
        check("beq_retired", longint'(retired), 9);
        check("beq_r6", longint'(dbg_rdata), 7);

        // Program B': BNE not taken, then HALT
        RESET = 1'b1;
        mem[8] = 16'h8BF8;  // BNE -8
        mem[9] = 16'hC000;
        do_reset();
        imem_ack = 1'b1;
        repeat (18) tick();
        check("bne_addr", longint'(imem_addr), 16'h0012);
        repeat (2) tick();
        check("bne_halted", longint'(halted), 1);
        check("bne_retired", longint'(retired), 10);

        // Program W: branch to 0xFFFE, then pc wraps to 0
        RESET = 1'b1;
        clear_mem();
        mem[0]     = 16'h83FE;  // B -2
        mem[32767] = 16'h4181;  // ADD r6,#1
        do_reset();
        imem_ack = 1'b1;
        repeat (2) tick();
        check("wrap_branch_addr", longint'(imem_addr), 16'hFFFE);
        repeat (2) tick();
        dbg_rsel = 3'd6;
        #1;
        check("wrap_addr", longint'(imem_addr), 16'h0000);
        check("wrap_r6", longint'(dbg_rdata), 1);

        // Random programs, random acks and debug selects, one async reset per round
        for (int round = 0; round < 6; round++) begin
            RESET = 1'b1;
            for (int i = 0; i < 32768; i++) mem[i] = rand_instr();
            do_reset();
            for (int cyc = 0; cyc < 500; cyc++) begin
                tick();
                imem_ack = ($urandom_range(0, 3) != 0);
                dbg_rsel = 3'($urandom);
                RESET    = (cyc == 250);
            end
        end
        RESET = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
